cache_16_ctrl: RTL and testbench

//  Read-miss controller for the 4-line x 4-word direct-mapped cache_16 (1-bit tag).
//  - Accepts CPU word reads and checks hit.
//  - On a miss, fetches the 4-word line from memory in four single-word handshakes.
//  - Loads the line into cache_16, then returns the data.
//  - Keeps its own per-line valid bits; cache_16's internal valid bits read 1 after reset.

---
 rtl/cache_16_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_cache_16_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_16_ctrl.sv
// Read-miss controller for the direct-mapped cache_16 (4 lines x 4 words, 1-bit tag).
// Define CACHE_16_CTRL_STATS_EN to add saturating hit_cnt / miss_cnt outputs.

module cache_16_ctrl #(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned LINES  = 4,
   parameter  int unsigned WORDS  = 4,
   parameter  int unsigned ADDR_W = 5,
   localparam int unsigned IW     = $clog2(LINES),
   localparam int unsigned OW     = $clog2(WORDS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   input  logic [ADDR_W-1:0]               req_addr,
   output logic                            req_ready,
   output logic                            resp_valid,
   output logic [WIDTH-1:0]                resp_data,
   output logic                            mem_rd,
   output logic [ADDR_W-1:0]               mem_addr,
   input  logic                            mem_ack,
   input  logic [WIDTH-1:0]                mem_rdata,
   output logic                            c_in_tag,
   output logic [IW-1:0]                   c_index,
   output logic [IW+OW-1:0]                c_offset,
   output logic [LINES-1:0]                c_load,
   output logic [WIDTH*LINES*WORDS-1:0]    c_line_bus,
   input  logic [WIDTH-1:0]                c_data,
   input  logic                            c_hit
`ifdef CACHE_16_CTRL_STATS_EN
   ,
   output logic [15:0]                     hit_cnt,
   output logic [15:0]                     miss_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_FILL,
      S_LOAD,
      S_RESP
   } state_t;

   state_t                      state_q, state_d;
   logic [ADDR_W-1:0]           addr_q, addr_d;
   logic [OW-1:0]               beat_q, beat_d;
   logic [WORDS-1:0][WIDTH-1:0] linebuf_q, linebuf_d;
   logic [LINES-1:0]            line_valid_q, line_valid_d;
   logic                        req_ready_q, req_ready_d;
   logic                        resp_valid_q, resp_valid_d;
   logic [WIDTH-1:0]            resp_data_q, resp_data_d;
   logic                        mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
   logic [LINES-1:0]            c_load_q, c_load_d;

`ifdef CACHE_16_CTRL_STATS_EN
   logic                        retry_q, retry_d;
   logic [15:0]                 hit_cnt_q, hit_cnt_d;
   logic [15:0]                 miss_cnt_q, miss_cnt_d;
`endif

   logic [IW-1:0]               idx;
   logic                        hit_eff;

   // cache_16 reports hit on stale lines after reset, so qualify with our own valid bits
   assign idx     = addr_q[OW +: IW];
   assign hit_eff = c_hit && line_valid_q[idx];

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beat_d       = beat_q;
      linebuf_d    = linebuf_q;
      line_valid_d = line_valid_q;
      resp_data_d  = resp_data_q;
`ifdef CACHE_16_CTRL_STATS_EN
      retry_d      = retry_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d  = req_addr;
               state_d = S_LOOKUP;
`ifdef CACHE_16_CTRL_STATS_EN
               retry_d = 1'b0;
`endif
            end
         end
         S_LOOKUP: begin
            if (hit_eff) begin
               resp_data_d = c_data;
               state_d     = S_RESP;
            end else begin
               beat_d  = '0;
               state_d = S_FILL;
            end
`ifdef CACHE_16_CTRL_STATS_EN
            if (!retry_q) begin
               if (hit_eff) begin
                  if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
               end else begin
                  if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
               end
            end
`endif
         end
         S_FILL: begin
            if (mem_ack && mem_rd_q) begin
               linebuf_d[beat_q] = mem_rdata;
               if (beat_q == OW'(WORDS - 1)) begin
                  beat_d  = '0;
                  state_d = S_LOAD;
               end else begin
                  beat_d = beat_q + OW'(1);
               end
            end
         end
         S_LOAD: begin
            line_valid_d[idx] = 1'b1;
            state_d           = S_LOOKUP;
`ifdef CACHE_16_CTRL_STATS_EN
            retry_d           = 1'b1;
`endif
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the state being entered
      req_ready_d  = (state_d == S_IDLE);
      resp_valid_d = (state_d == S_RESP);
      mem_rd_d     = (state_d == S_FILL);
      mem_addr_d   = mem_rd_d ? {addr_d[ADDR_W-1:OW], beat_d} : '0;
      c_load_d     = (state_d == S_LOAD) ? (LINES'(1) << idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         beat_q       <= '0;
         linebuf_q    <= '0;
         line_valid_q <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         mem_rd_q     <= 1'b0;
         mem_addr_q   <= '0;
         c_load_q     <= '0;
`ifdef CACHE_16_CTRL_STATS_EN
         retry_q      <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beat_q       <= beat_d;
         linebuf_q    <= linebuf_d;
         line_valid_q <= line_valid_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         mem_rd_q     <= mem_rd_d;
         mem_addr_q   <= mem_addr_d;
         c_load_q     <= c_load_d;
`ifdef CACHE_16_CTRL_STATS_EN
         retry_q      <= retry_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign mem_rd     = mem_rd_q;
   assign mem_addr   = mem_addr_q;
   assign c_load     = c_load_q;
   assign c_in_tag   = addr_q[ADDR_W-1];
   assign c_index    = idx;
   assign c_offset   = addr_q[IW+OW-1:0];

   // Every word slot j of the cache bus carries linebuf[j % WORDS]
   assign c_line_bus = {LINES{linebuf_q}};

`ifdef CACHE_16_CTRL_STATS_EN
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_16_ctrl.sv
// Bench for cache_16_ctrl: behavioural cache_16 and memory models plus a line-level reference.
// Honours CACHE_16_CTRL_STATS_EN for the counter checks.

module tb_cache_16_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [4:0]    req_addr;
   logic          req_ready;
   logic          resp_valid;
   logic [31:0]   resp_data;
   logic          mem_rd;
   logic [4:0]    mem_addr;
   logic          mem_ack = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic          c_in_tag;
   logic [1:0]    c_index;
   logic [3:0]    c_offset;
   logic [3:0]    c_load;
   logic [511:0]  c_line_bus;
   logic [31:0]   c_data;
   logic          c_hit;
`ifdef CACHE_16_CTRL_STATS_EN
   logic [15:0]   hit_cnt;
   logic [15:0]   miss_cnt;
`endif

   cache_16_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .c_in_tag   (c_in_tag),
      .c_index    (c_index),
      .c_offset   (c_offset),
      .c_load     (c_load),
      .c_line_bus (c_line_bus),
      .c_data     (c_data),
      .c_hit      (c_hit)
`ifdef CACHE_16_CTRL_STATS_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // cache_16 model: tags/data power up as 0 and always read as valid
   logic [31:0] cdata [16] = '{default: '0};
   logic        ctag  [4]  = '{default: 1'b0};

   assign c_data = cdata[c_offset];
   assign c_hit  = (ctag[c_index] == c_in_tag);

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (c_load[i]) begin
            ctag[i] <= c_in_tag;
            for (int w = 0; w < 4; w++)
               cdata[i*4+w] <= c_line_bus[(i*4+w)*32 +: 32];
         end
      end
   end

   // Memory model: ack after mem_delay wait cycles per beat; optional spurious acks when idle
   logic [31:0] mem [32];
   int          mem_delay = 0;
   bit          spur_en = 1'b0;
   int          beat_wait = 0;
   logic [4:0]  beat_addr = '0;
   int          stable_bad = 0;
   logic [4:0]  ackq [$];

   always @(negedge clk) begin
      if (mem_rd) begin
         if (beat_wait == 0) beat_addr = mem_addr;
         else if (mem_addr !== beat_addr) stable_bad++;
         if (beat_wait >= mem_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            ackq.push_back(mem_addr);
            beat_wait = 0;
         end else begin
            mem_ack = 1'b0;
            beat_wait++;
         end
      end else begin
         beat_wait = 0;
         mem_ack   = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rdata = $urandom;
      end
   end

   // Reference: which tag each line holds, if any
   bit   rv [4];
   logic rt [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_data"},  resp_data,       32'd0);
      chk({tag, "_mem_rd"},     32'(mem_rd),     32'd0);
      chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
      chk({tag, "_c_load"},     32'(c_load),     32'd0);
      chk({tag, "_c_offset"},   32'({c_in_tag, c_offset}), 32'd0);
      chk({tag, "_line_bus"},   32'(c_line_bus != '0), 32'd0);
   endtask

   task automatic clear_ref();
      for (int i = 0; i < 4; i++) rv[i] = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] a, input int d, input bit hold);
      int         idx = int'(a[3:2]);
      bit         hit = rv[idx] && (rt[idx] == a[4]);
      int         exp_lat = hit ? 2 : 4 * (d + 1) + 4;
      int         cyc = 0;
      bit         got = 1'b0;
      int         loads = 0;
      logic [3:0] load_val = '0;
      int         busy_bad = 0;
      logic [31:0] rdata = '0;

      @(negedge clk);
      mem_delay  = d;
      ackq.delete();
      stable_bad = 0;
      chk("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk);
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (hold) req_addr = 5'($urandom);
         else      req_valid = 1'b0;
         if (req_ready) busy_bad++;
         if (c_load != '0) begin
            loads++;
            load_val = c_load;
         end
         if (resp_valid) begin
            got   = 1'b1;
            rdata = resp_data;
         end
      end
      req_valid = 1'b0;
      chk("resp_seen", 32'(got), 32'd1);
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("resp_data", rdata, mem[a]);
      chk("busy_ready", 32'(busy_bad), 32'd0);
      chk("ack_count", 32'(ackq.size()), hit ? 32'd0 : 32'd4);
      for (int k = 0; k < ackq.size() && k < 4; k++)
         chk("mem_addr_seq", 32'(ackq[k]), 32'({a[4:2], 2'(k)}));
      chk("mem_addr_stable", 32'(stable_bad), 32'd0);
      chk("load_count", 32'(loads), hit ? 32'd0 : 32'd1);
      if (!hit) chk("load_onehot", 32'(load_val), 32'(4'b0001 << idx));
      @(negedge clk);
      chk("resp_pulse", 32'(resp_valid), 32'd0);
      chk("ready_after", 32'(req_ready), 32'd1);
      if (!hit) begin
         rv[idx] = 1'b1;
         rt[idx] = a[4];
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[4+i] = 32'hA0 + 32'(i);
      clear_ref();
      rst       = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b1;

      // First miss fills line 1, then a hit in the same line
      do_read(5'h04, 0, 1'b0);
      do_read(5'h06, 0, 1'b0);

      // Tag conflict on index 1 evicts, and the old tag misses again
      do_read(5'h14, 0, 1'b0);
      do_read(5'h04, 0, 1'b0);

      // Slow memory with req_valid held high throughout
      do_read(5'h1C, 3, 1'b1);

      // Reset during beat 2 of a fill
      @(negedge clk);
      mem_delay = 3;
      ackq.delete();
      req_valid = 1'b1;
      req_addr  = 5'h08;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 100 && ackq.size() < 2; c++) @(negedge clk);
      chk("reset_reached_beat2", 32'(ackq.size()), 32'd2);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("midfill_reset");
      rst = 1'b1;
      clear_ref();
      do_read(5'h08, 0, 1'b0);
      do_read(5'h04, 1, 1'b0);
      do_read(5'h05, 0, 1'b0);

      // Random traffic with spurious idle acks
      spur_en = 1'b1;
      for (int n = 0; n < 40; n++)
         do_read(5'($urandom_range(0, 31)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      spur_en = 1'b0;

`ifdef CACHE_16_CTRL_STATS_EN
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      clear_ref();
      chk("hit_cnt_reset",  32'(hit_cnt),  32'd0);
      chk("miss_cnt_reset", 32'(miss_cnt), 32'd0);
      do_read(5'h10, 0, 1'b0);
      do_read(5'h11, 0, 1'b0);
      do_read(5'h12, 0, 1'b0);
      do_read(5'h13, 0, 1'b0);
      chk("miss_cnt", 32'(miss_cnt), 32'd1);
      chk("hit_cnt",  32'(hit_cnt),  32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
